// File: rtl/pack_16_12.sv
// rtl/pack_16_12.sv - narrows signed 16b words to 12b and packs four of them into three 16b words
`timescale 1ns/1ps
module pack_16_12 #(
    parameter bit SATURATE = 1'b1,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [15:0]      out_data,
    output logic             out_valid,
    output logic             out_last,
    input  logic             out_ready,
    output logic [CNT_W-1:0] ovf_count,
    output logic             busy
);

    typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

    state_t             state_q;
    logic [1:0]         phase_q;
    logic [11:0]        res_q;
    logic [15:0]        pend_q;
    logic [15:0]        out_data_q;
    logic               out_valid_q;
    logic               out_last_q;
    logic [CNT_W-1:0]   ovf_q;

    logic               in_range;
    logic               accept;
    logic               out_free;
    logic [11:0]        elem_d;

    assign in_range = (&in_data[15:11]) | ~(|in_data[15:11]);
    assign out_free = !out_valid_q || out_ready;
    assign in_ready = (state_q == RUN) && out_free;
    assign accept   = in_valid && in_ready;

    always_comb begin
        elem_d = in_data[11:0];
        if (!in_range && SATURATE)
            elem_d = in_data[15] ? 12'h800 : 12'h7FF;
    end

    // The residue always holds the last accepted element; each phase uses only its unsent low bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            phase_q     <= 2'd0;
            res_q       <= 12'h000;
            pend_q      <= 16'h0000;
            out_data_q  <= 16'h0000;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            ovf_q       <= '0;
        end else begin
            if (accept && !in_range && (ovf_q != {CNT_W{1'b1}}))
                ovf_q <= ovf_q + {{(CNT_W-1){1'b0}}, 1'b1};

            if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
            end

            case (state_q)
                RUN: begin
                    if (accept) begin
                        res_q <= elem_d;
                        case (phase_q)
                            2'd0: begin
                                if (in_last) begin
                                    out_data_q  <= {elem_d, 4'h0};
                                    out_valid_q <= 1'b1;
                                    out_last_q  <= 1'b1;
                                    phase_q     <= 2'd0;
                                end else begin
                                    phase_q <= 2'd1;
                                end
                            end
                            2'd1: begin
                                out_data_q  <= {res_q, elem_d[11:8]};
                                out_valid_q <= 1'b1;
                                out_last_q  <= 1'b0;
                                if (in_last) begin
                                    pend_q  <= {elem_d[7:0], 8'h00};
                                    state_q <= FLUSH;
                                    phase_q <= 2'd0;
                                end else begin
                                    phase_q <= 2'd2;
                                end
                            end
                            2'd2: begin
                                out_data_q  <= {res_q[7:0], elem_d[11:4]};
                                out_valid_q <= 1'b1;
                                out_last_q  <= 1'b0;
                                if (in_last) begin
                                    pend_q  <= {elem_d[3:0], 12'h000};
                                    state_q <= FLUSH;
                                    phase_q <= 2'd0;
                                end else begin
                                    phase_q <= 2'd3;
                                end
                            end
                            default: begin
                                out_data_q  <= {res_q[3:0], elem_d};
                                out_valid_q <= 1'b1;
                                out_last_q  <= in_last;
                                phase_q     <= 2'd0;
                            end
                        endcase
                    end
                end
                default: begin
                    // FLUSH: the residue word follows once the word ahead of it is taken.
                    if (out_free) begin
                        out_data_q  <= pend_q;
                        out_valid_q <= 1'b1;
                        out_last_q  <= 1'b1;
                        state_q     <= RUN;
                        phase_q     <= 2'd0;
                    end
                end
            endcase
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign ovf_count = ovf_q;
    assign busy      = (phase_q != 2'd0) || (state_q == FLUSH) || out_valid_q;

endmodule

// File: tb/tb_pack_16_12.sv
// tb/tb_pack_16_12.sv - scoreboard bench for pack_16_12, saturating and truncating instances side by side
`timescale 1ns/1ps
module tb_pack_16_12;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] in_data = 16'h0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b1;

    logic        in_ready_s, out_valid_s, out_last_s, busy_s;
    logic [15:0] out_data_s;
    logic [7:0]  ovf_s;
    logic        in_ready_t, out_valid_t, out_last_t, busy_t;
    logic [15:0] out_data_t;
    logic [7:0]  ovf_t;

    int n_tests = 0;
    int n_fail  = 0;

    logic [16:0] q_s[$];
    logic [16:0] q_t[$];
    logic [16:0] last_s = '0;
    logic [16:0] last_t = '0;
    logic [63:0] acc_s, acc_t;
    int          nb_s, nb_t;
    int          m_ovf;

    always #5 clk = ~clk;

    pack_16_12 #(.SATURATE(1'b1), .CNT_W(8)) u_sat (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready_s), .out_data(out_data_s), .out_valid(out_valid_s), .out_last(out_last_s),
        .out_ready(out_ready), .ovf_count(ovf_s), .busy(busy_s)
    );

    pack_16_12 #(.SATURATE(1'b0), .CNT_W(8)) u_trn (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready_t), .out_data(out_data_t), .out_valid(out_valid_t), .out_last(out_last_t),
        .out_ready(out_ready), .ovf_count(ovf_t), .busy(busy_t)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] elem(input logic [15:0] d, input bit sat);
        logic in_rng;
        in_rng = (d[15:11] == 5'b00000) || (d[15:11] == 5'b11111);
        if (!in_rng && sat) return d[15] ? 12'h800 : 12'h7FF;
        return d[11:0];
    endfunction

    // Reference packer: a plain MSB-first bit accumulator.
    task automatic pack_one(input logic [11:0] e, input logic l, inout logic [63:0] acc,
                            inout int nb, output logic [16:0] w[$]);
        logic [15:0] word;
        w = {};
        acc = (acc << 12) | {52'h0, e};
        nb  = nb + 12;
        while (nb >= 16) begin
            word = 16'((acc >> (nb - 16)) & 64'hFFFF);
            nb   = nb - 16;
            w.push_back({(l && nb == 0), word});
        end
        if (l && nb > 0) begin
            word = 16'((acc << (16 - nb)) & 64'hFFFF);
            w.push_back({1'b1, word});
            nb = 0;
        end
    endtask

    task automatic model_push(input logic [15:0] d, input logic l);
        logic [16:0] w[$];
        pack_one(elem(d, 1'b1), l, acc_s, nb_s, w);
        foreach (w[i]) q_s.push_back(w[i]);
        pack_one(elem(d, 1'b0), l, acc_t, nb_t, w);
        foreach (w[i]) q_t.push_back(w[i]);
        if (!((d[15:11] == 5'b00000) || (d[15:11] == 5'b11111)) && m_ovf < 255)
            m_ovf++;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid_s && out_ready) begin
                if (q_s.size() == 0) chk("sat_unexpected_word", {15'h0, out_last_s, out_data_s}, 32'h0);
                else chk("sat_word", {15'h0, out_last_s, out_data_s}, {15'h0, q_s.pop_front()});
                last_s = {out_last_s, out_data_s};
            end
            if (out_valid_t && out_ready) begin
                if (q_t.size() == 0) chk("trn_unexpected_word", {15'h0, out_last_t, out_data_t}, 32'h0);
                else chk("trn_word", {15'h0, out_last_t, out_data_t}, {15'h0, q_t.pop_front()});
                last_t = {out_last_t, out_data_t};
            end
        end
    end

    task automatic send(input logic [15:0] d, input logic l);
        int t;
        in_data  = d;
        in_valid = 1'b1;
        in_last  = l;
        t = 0;
        @(negedge clk);
        while (!(in_ready_s && in_ready_t)) begin
            t++;
            if (t > 100) begin
                chk("send_timeout", 32'd0, 32'd1);
                in_valid = 1'b0;
                in_last  = 1'b0;
                return;
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        model_push(d, l);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((q_s.size() != 0 || q_t.size() != 0) && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("drain_left", q_s.size() + q_t.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        in_last  = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        q_s = {};
        q_t = {};
        acc_s = '0; acc_t = '0;
        nb_s = 0; nb_t = 0;
        m_ovf = 0;
        chk("rst_out_valid", {31'h0, out_valid_s | out_valid_t}, 32'd0);
        chk("rst_out_data",  {out_data_s, out_data_t}, 32'd0);
        chk("rst_out_last",  {31'h0, out_last_s | out_last_t}, 32'd0);
        chk("rst_ovf",       {16'h0, ovf_s, ovf_t}, 32'd0);
        chk("rst_busy",      {31'h0, busy_s | busy_t}, 32'd0);
        chk("rst_in_ready",  {30'h0, in_ready_s, in_ready_t}, 32'd3);
    endtask

    task automatic chk_ovf(input string tag);
        chk({tag, "_sat"}, {24'h0, ovf_s}, m_ovf);
        chk({tag, "_trn"}, {24'h0, ovf_t}, m_ovf);
    endtask

    initial begin
        logic [16:0] hold;
        acc_s = '0; acc_t = '0; nb_s = 0; nb_t = 0; m_ovf = 0;
        repeat (2) @(posedge clk);
        do_reset();

        // Test 1: in-range packet, exact multiple of four
        send(16'h0123, 1'b0); send(16'hFC56, 1'b0); send(16'h0789, 1'b0); send(16'h07AB, 1'b1);
        drain();
        chk("t1_last_sat", {15'h0, last_s}, 32'h197AB);
        chk("t1_last_trn", {15'h0, last_t}, 32'h197AB);
        chk_ovf("t1_ovf");
        chk("t1_ovf_zero", {24'h0, ovf_s}, 32'd0);

        // Test 2: out-of-range elements, saturate vs truncate
        do_reset();
        send(16'h1234, 1'b0); send(16'h8000, 1'b0); send(16'h0000, 1'b0); send(16'h0000, 1'b1);
        drain();
        chk("t2_ovf_const", {16'h0, ovf_s, ovf_t}, 32'h0202);

        // Test 3: flush after two elements, then a lone element
        do_reset();
        send(16'h0123, 1'b0);
        send(16'h0456, 1'b1);
        chk("t3_flush_in_ready", {30'h0, in_ready_s, in_ready_t}, 32'd0);
        chk("t3_flush_busy", {31'h0, busy_s}, 32'd1);
        drain();
        chk("t3_flush_last", {15'h0, last_s}, 32'h15600);
        send(16'h0ABC, 1'b1);
        drain();
        chk("t3_single_sat", {15'h0, last_s}, 32'h17FF0);
        chk("t3_single_trn", {15'h0, last_t}, 32'h1ABC0);
        chk_ovf("t3_ovf");
        chk("t3_ovf_one", {24'h0, ovf_s}, 32'd1);

        // Test 4: backpressure on a W2 with a phase-0 element waiting
        do_reset();
        send(16'h0111, 1'b0); send(16'h0222, 1'b0); send(16'h0333, 1'b0);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        send(16'h0444, 1'b0);
        in_data  = 16'h0555;
        in_valid = 1'b1;
        in_last  = 1'b1;
        hold = {out_last_s, out_data_s};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t4_hold_data", {15'h0, out_last_s, out_data_s}, {15'h0, hold});
            chk("t4_hold_valid", {31'h0, out_valid_s}, 32'd1);
            chk("t4_in_ready", {30'h0, in_ready_s, in_ready_t}, 32'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(16'h0555, 1'b1);
        drain();
        chk("t4_last", {15'h0, last_s}, 32'h15550);

        // Test 5: reset while flushing
        do_reset();
        out_ready = 1'b0;
        send(16'h0123, 1'b0);
        send(16'h0456, 1'b1);
        chk("t5_busy_pre", {31'h0, busy_s}, 32'd1);
        do_reset();
        out_ready = 1'b1;
        send(16'h0123, 1'b0); send(16'hFC56, 1'b0); send(16'h0789, 1'b0); send(16'h07AB, 1'b1);
        drain();
        chk("t5_last", {15'h0, last_s}, 32'h197AB);

        // Test 6: overflow counter saturation
        do_reset();
        for (int i = 0; i < 300; i++)
            send((i % 2) ? 16'h8001 : 16'h7FFE, (i % 4) == 3);
        drain();
        chk_ovf("t6_ovf");
        chk("t6_ovf_sat", {16'h0, ovf_s, ovf_t}, 32'hFFFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
